// File: rtl/turret_pkg.sv
// ---------------------------------------------------------------------------
// turret_pkg
// Shared definitions for the APB turret PWM block:
//   - register word offsets (byte address bits [4:2])
//   - CTRL / STATUS bit positions
//   - fire FSM state encoding
// ---------------------------------------------------------------------------
package turret_pkg;

  // Word offsets: byte address = offset * 4
  localparam logic [2:0] OFF_CTRL   = 3'd0;  // 0x00
  localparam logic [2:0] OFF_PERIOD = 3'd1;  // 0x04
  localparam logic [2:0] OFF_PULSE0 = 3'd2;  // 0x08
  localparam logic [2:0] OFF_PULSE1 = 3'd3;  // 0x0C
  localparam logic [2:0] OFF_FIRE   = 3'd4;  // 0x10
  localparam logic [2:0] OFF_STATUS = 3'd5;  // 0x14
  localparam logic [2:0] OFF_LAST   = OFF_STATUS;

  // CTRL bits
  localparam int CTRL_EN  = 0;
  localparam int CTRL_ARM = 1;

  // STATUS bits
  localparam int STAT_BUSY     = 0;
  localparam int STAT_REJ      = 1;
  localparam int STAT_FCNT_LSB = 16;

  // FIRE register bits
  localparam int FIRE_REQ = 0;

  typedef enum logic {
    FIRE_IDLE   = 1'b0,
    FIRE_FIRING = 1'b1
  } fire_state_t;

endpackage

// File: rtl/pwm_channel.sv
// ---------------------------------------------------------------------------
// pwm_channel
// One servo PWM output: high while the frame count is below the shadowed
// pulse width. Output is registered so it never glitches on the compare.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset
//   i_en     channel enable (CTRL.EN)
//   i_count  current frame tick count
//   i_pulse  shadowed pulse width in ticks
//   o_pwm    registered PWM output
// ---------------------------------------------------------------------------
module pwm_channel (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [15:0] i_count,
  input  logic [15:0] i_pulse,
  output logic        o_pwm
);

  logic r_pwm;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= i_en & (i_count < i_pulse);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/apb_turret_pwm.sv
// ---------------------------------------------------------------------------
// apb_turret_pwm
// APB3 slave driving two servo PWM channels (pan, tilt) and a one-shot fire
// solenoid pulse. Firmware may rewrite pulse widths at any time; the PWM
// engine only picks them up at a frame boundary through shadow registers.
// Ports:
//   PCLK      clock
//   PRESET    synchronous active-high reset
//   PSEL, PENABLE, PWRITE, PADDR[7:0], PWDATA[31:0]   APB request
//   PRDATA[31:0]  combinational read data (0 when not selected)
//   PREADY        constant 1 (zero wait states)
//   PSLVERR       error for word offsets above STATUS
//   PWM_PAN, PWM_TILT  registered servo PWM outputs
//   FIRE_OUT           registered solenoid drive
// ---------------------------------------------------------------------------
module apb_turret_pwm
  import turret_pkg::*;
#(
  parameter int PRESCALE   = 100,
  parameter int PERIOD_RST = 20000,
  parameter int MIN_PULSE  = 1000,
  parameter int MAX_PULSE  = 2000,
  parameter int FIRE_LEN   = 50000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        PWM_PAN,
  output logic        PWM_TILT,
  output logic        FIRE_OUT
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(PRESCALE - 1);
  localparam logic [15:0]   C_MIN       = 16'(MIN_PULSE);
  localparam logic [15:0]   C_MAX       = 16'(MAX_PULSE);
  localparam logic [15:0]   C_PERIOD_LO = 16'(MAX_PULSE + 1);
  localparam logic [15:0]   C_PERIOD_RST = 16'(PERIOD_RST);
  localparam logic [15:0]   C_FIRE_LAST = 16'(FIRE_LEN - 1);

  function automatic logic [15:0] clamp_pulse(input logic [15:0] v);
    if (v < C_MIN) begin
      return C_MIN;
    end else if (v > C_MAX) begin
      return C_MAX;
    end
    return v;
  endfunction

  localparam logic [15:0] C_PULSE_RST = clamp_pulse(16'd1500);

  // ---------------- APB decode ----------------
  logic [2:0] w_idx;
  logic       w_mapped;
  logic       w_wr;
  logic       w_wr_ctrl, w_wr_period, w_wr_pulse0, w_wr_pulse1, w_wr_status;
  logic       w_fire_req;
  logic       w_unused;

  assign w_idx       = PADDR[4:2];
  assign w_mapped    = (w_idx <= OFF_LAST);
  assign w_wr        = PSEL & PENABLE & PWRITE & w_mapped;
  assign w_wr_ctrl   = w_wr & (w_idx == OFF_CTRL);
  assign w_wr_period = w_wr & (w_idx == OFF_PERIOD);
  assign w_wr_pulse0 = w_wr & (w_idx == OFF_PULSE0);
  assign w_wr_pulse1 = w_wr & (w_idx == OFF_PULSE1);
  assign w_wr_status = w_wr & (w_idx == OFF_STATUS);
  assign w_fire_req  = w_wr & (w_idx == OFF_FIRE) & PWDATA[FIRE_REQ];

  // Address/data bits that no register uses.
  assign w_unused = ^{PADDR[7:5], PADDR[1:0], PWDATA[31:16]};

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & (w_idx > OFF_LAST);

  // ---------------- live registers ----------------
  logic [1:0]  r_ctrl;
  logic [15:0] r_period;
  logic [15:0] r_pulse0;
  logic [15:0] r_pulse1;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_ctrl   <= 2'b00;
      r_period <= C_PERIOD_RST;
      r_pulse0 <= C_PULSE_RST;
      r_pulse1 <= C_PULSE_RST;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= PWDATA[1:0];
      end
      if (w_wr_period) begin
        // A period not longer than the widest pulse would leave the output
        // stuck high, so it is raised to one tick beyond MAX_PULSE.
        r_period <= (PWDATA[15:0] < C_PERIOD_LO) ? C_PERIOD_LO : PWDATA[15:0];
      end
      if (w_wr_pulse0) begin
        r_pulse0 <= clamp_pulse(PWDATA[15:0]);
      end
      if (w_wr_pulse1) begin
        r_pulse1 <= clamp_pulse(PWDATA[15:0]);
      end
    end
  end

  logic w_en, w_arm;
  assign w_en  = r_ctrl[CTRL_EN];
  assign w_arm = r_ctrl[CTRL_ARM];

  // ---------------- tick prescaler ----------------
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PRESC_LAST);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // ---------------- frame counter + shadows ----------------
  logic [15:0] r_fcnt;
  logic [15:0] r_period_sh;
  logic [15:0] r_pulse0_sh;
  logic [15:0] r_pulse1_sh;
  logic [15:0] r_frame_cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_fcnt      <= 16'd0;
      r_period_sh <= C_PERIOD_RST;
      r_pulse0_sh <= C_PULSE_RST;
      r_pulse1_sh <= C_PULSE_RST;
      r_frame_cnt <= 16'd0;
    end else if (!w_en) begin
      // Disabled: shadows follow the live registers so enabling starts a
      // frame with whatever firmware last wrote.
      r_fcnt      <= 16'd0;
      r_period_sh <= r_period;
      r_pulse0_sh <= r_pulse0;
      r_pulse1_sh <= r_pulse1;
    end else if (w_tick) begin
      if (r_fcnt == r_period_sh - 16'd1) begin
        // Reload samples the live registers before this edge, so a write
        // landing on the wrap edge is picked up one frame later.
        r_fcnt      <= 16'd0;
        r_period_sh <= r_period;
        r_pulse0_sh <= r_pulse0;
        r_pulse1_sh <= r_pulse1;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_fcnt <= r_fcnt + 16'd1;
      end
    end
  end

  pwm_channel u_pan (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_en    (w_en),
    .i_count (r_fcnt),
    .i_pulse (r_pulse0_sh),
    .o_pwm   (PWM_PAN)
  );

  pwm_channel u_tilt (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_en    (w_en),
    .i_count (r_fcnt),
    .i_pulse (r_pulse1_sh),
    .o_pwm   (PWM_TILT)
  );

  // ---------------- fire FSM ----------------
  fire_state_t r_fire_state;
  logic        r_fire_out;
  logic [15:0] r_fire_len;
  logic        r_fire_rej;
  logic        w_busy;
  logic        w_reject;

  assign w_busy   = (r_fire_state == FIRE_FIRING);
  assign w_reject = w_fire_req & (w_busy | ~w_arm);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_fire_state <= FIRE_IDLE;
      r_fire_out   <= 1'b0;
      r_fire_len   <= 16'd0;
      r_fire_rej   <= 1'b0;
    end else begin
      // Sticky reject flag; a new reject beats a simultaneous W1C.
      if (w_reject) begin
        r_fire_rej <= 1'b1;
      end else if (w_wr_status && PWDATA[STAT_REJ]) begin
        r_fire_rej <= 1'b0;
      end

      case (r_fire_state)
        FIRE_IDLE: begin
          if (w_fire_req && w_arm) begin
            r_fire_state <= FIRE_FIRING;
            r_fire_out   <= 1'b1;
            r_fire_len   <= 16'd0;
          end
        end
        FIRE_FIRING: begin
          if (!w_arm) begin
            // Disarm aborts the pulse immediately.
            r_fire_state <= FIRE_IDLE;
            r_fire_out   <= 1'b0;
          end else if (w_tick) begin
            if (r_fire_len == C_FIRE_LAST) begin
              r_fire_state <= FIRE_IDLE;
              r_fire_out   <= 1'b0;
            end else begin
              r_fire_len <= r_fire_len + 16'd1;
            end
          end
        end
        default: begin
          r_fire_state <= FIRE_IDLE;
          r_fire_out   <= 1'b0;
        end
      endcase
    end
  end

  assign FIRE_OUT = r_fire_out;

  // ---------------- read mux ----------------
  always_comb begin
    PRDATA = 32'd0;
    if (PSEL) begin
      case (w_idx)
        OFF_CTRL:   PRDATA = {30'd0, r_ctrl};
        OFF_PERIOD: PRDATA = {16'd0, r_period};
        OFF_PULSE0: PRDATA = {16'd0, r_pulse0};
        OFF_PULSE1: PRDATA = {16'd0, r_pulse1};
        OFF_STATUS: PRDATA = {r_frame_cnt, 14'd0, r_fire_rej, w_busy};
        default:    PRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_turret_pwm.sv
module tb_apb_turret_pwm;

  localparam int P     = 2;
  localparam int PRST  = 40;
  localparam int MINP  = 5;
  localparam int MAXP  = 20;
  localparam int FLEN  = 10;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_PERIOD = 8'h04;
  localparam logic [7:0] A_PULSE0 = 8'h08;
  localparam logic [7:0] A_PULSE1 = 8'h0C;
  localparam logic [7:0] A_FIRE   = 8'h10;
  localparam logic [7:0] A_STATUS = 8'h14;

  logic        PCLK, PRESET, PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, PWM_PAN, PWM_TILT, FIRE_OUT;

  int checks;
  int failures;

  apb_turret_pwm #(
    .PRESCALE(P), .PERIOD_RST(PRST), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .FIRE_LEN(FLEN)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PWM_PAN(PWM_PAN), .PWM_TILT(PWM_TILT), .FIRE_OUT(FIRE_OUT)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Reference rules
  function automatic int exp_pulse(input int v);
    if (v < MINP) return MINP;
    if (v > MAXP) return MAXP;
    return v;
  endfunction

  function automatic int exp_period(input int v);
    return (v < MAXP + 1) ? MAXP + 1 : v;
  endfunction

  // Output monitor: high-run lengths and rise times, sampled on the falling edge.
  int cyc;
  int pan_run, tilt_run, fire_run;
  int pan_high_q[$];
  int tilt_high_q[$];
  int fire_high_q[$];
  int pan_rise_q[$];

  initial begin
    cyc = 0; pan_run = 0; tilt_run = 0; fire_run = 0;
    forever begin
      @(negedge PCLK);
      cyc++;
      if (PWM_PAN === 1'b1) begin
        if (pan_run == 0) pan_rise_q.push_back(cyc);
        pan_run++;
      end else begin
        if (pan_run > 0) pan_high_q.push_back(pan_run);
        pan_run = 0;
      end
      if (PWM_TILT === 1'b1) tilt_run++;
      else begin
        if (tilt_run > 0) tilt_high_q.push_back(tilt_run);
        tilt_run = 0;
      end
      if (FIRE_OUT === 1'b1) fire_run++;
      else begin
        if (fire_run > 0) fire_high_q.push_back(fire_run);
        fire_run = 0;
      end
    end
  end

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    d = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_pan_rise();
    int r0;
    r0 = pan_rise_q.size();
    for (int k = 0; k < 400 && pan_rise_q.size() <= r0; k++) @(posedge PCLK);
    checks++;
    if (pan_rise_q.size() <= r0) begin
      failures++;
      $display("FAIL pan_rise_wait: no PWM_PAN rise within 400 cycles");
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    checks++;
    if ({PWM_PAN, PWM_TILT, FIRE_OUT, PSLVERR} !== 4'b0000 || PREADY !== 1'b1 || PRDATA !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: pan=%b tilt=%b fire=%b slverr=%b ready=%b prdata=%h, want 0 0 0 0 1 0",
               PWM_PAN, PWM_TILT, FIRE_OUT, PSLVERR, PREADY, PRDATA);
    end
    PRESET = 1'b0;
    apb_read(A_CTRL, d, e);   checks++;
    if (d !== 32'd0 || e !== 1'b0) begin failures++; $display("FAIL reset_ctrl: got %0d err=%b want 0", d, e); end
    apb_read(A_PERIOD, d, e); checks++;
    if (d !== PRST) begin failures++; $display("FAIL reset_period: got %0d want %0d", d, PRST); end
    apb_read(A_PULSE0, d, e); checks++;
    if (d !== exp_pulse(1500)) begin failures++; $display("FAIL reset_pulse0: got %0d want %0d", d, exp_pulse(1500)); end
    apb_read(A_PULSE1, d, e); checks++;
    if (d !== exp_pulse(1500)) begin failures++; $display("FAIL reset_pulse1: got %0d want %0d", d, exp_pulse(1500)); end
    apb_read(A_FIRE, d, e);   checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL reset_fire_rd: got %0d want 0", d); end
    apb_read(A_STATUS, d, e); checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL reset_status: got %h want 0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d; logic e;
    int v;
    apb_write(A_PULSE0, 32'd3);  apb_read(A_PULSE0, d, e); checks++;
    if (d !== 32'd5) begin failures++; $display("FAIL pulse0_clamp_lo: got %0d want 5", d); end
    apb_write(A_PULSE1, 32'd99); apb_read(A_PULSE1, d, e); checks++;
    if (d !== 32'd20) begin failures++; $display("FAIL pulse1_clamp_hi: got %0d want 20", d); end
    apb_write(A_PERIOD, 32'd10); apb_read(A_PERIOD, d, e); checks++;
    if (d !== 32'd21) begin failures++; $display("FAIL period_floor: got %0d want 21", d); end
    for (int i = 0; i < 6; i++) begin
      v = int'($urandom_range(0, 40));
      apb_write(A_PULSE0, 32'(v)); apb_read(A_PULSE0, d, e); checks++;
      if (d !== 32'(exp_pulse(v))) begin failures++; $display("FAIL rand_pulse0: wrote %0d got %0d want %0d", v, d, exp_pulse(v)); end
      v = int'($urandom_range(0, 60));
      apb_write(A_PERIOD, 32'(v)); apb_read(A_PERIOD, d, e); checks++;
      if (d !== 32'(exp_period(v))) begin failures++; $display("FAIL rand_period: wrote %0d got %0d want %0d", v, d, exp_period(v)); end
    end
    apb_write(A_CTRL, 32'd0);
    apb_write(8'h18, 32'hFFFF_FFFF);
    apb_read(8'h18, d, e); checks++;
    if (d !== 32'd0 || e !== 1'b1) begin failures++; $display("FAIL unmapped_18: prdata=%h slverr=%b want 0 1", d, e); end
    apb_read(8'h1C, d, e); checks++;
    if (d !== 32'd0 || e !== 1'b1) begin failures++; $display("FAIL unmapped_1c: prdata=%h slverr=%b want 0 1", d, e); end
    apb_read(A_CTRL, d, e); checks++;
    if (d !== 32'd0 || e !== 1'b0) begin failures++; $display("FAIL unmapped_no_effect: ctrl=%h err=%b want 0 0", d, e); end
  endtask

  task automatic test_pwm();
    logic [31:0] d; logic e;
    int idx, idx_t, fc1, fc2, p, tp, per;
    apb_write(A_PERIOD, 32'd40);
    apb_write(A_PULSE0, 32'd8);
    apb_write(A_PULSE1, 32'd15);
    apb_write(A_CTRL, 32'd1);
    idx = pan_high_q.size();
    for (int k = 0; k < 1000 && (pan_high_q.size() < idx + 3 || pan_rise_q.size() < 3); k++) @(posedge PCLK);
    checks++;
    if (pan_high_q.size() < idx + 3) begin
      failures++; $display("FAIL pwm_steady: timeout waiting for PWM_PAN pulses");
    end else begin
      if (pan_high_q[idx + 2] != 16) begin failures++; $display("FAIL pwm_high16: got %0d cycles want 16", pan_high_q[idx + 2]); end
      checks++;
      if (pan_rise_q[pan_rise_q.size() - 1] - pan_rise_q[pan_rise_q.size() - 2] != PRST * P) begin
        failures++; $display("FAIL pwm_period80: got %0d want %0d",
          pan_rise_q[pan_rise_q.size() - 1] - pan_rise_q[pan_rise_q.size() - 2], PRST * P);
      end
    end
    // Mid-frame update of PULSE0: current frame keeps the old width.
    wait_pan_rise();
    idx = pan_high_q.size();
    apb_write(A_PULSE0, 32'd12);
    for (int k = 0; k < 1000 && pan_high_q.size() < idx + 2; k++) @(posedge PCLK);
    checks++;
    if (pan_high_q.size() < idx + 2) begin
      failures++; $display("FAIL pwm_mid_update: timeout");
    end else if (pan_high_q[idx] != 16 || pan_high_q[idx + 1] != 24) begin
      failures++; $display("FAIL pwm_mid_update: runs %0d,%0d want 16,24", pan_high_q[idx], pan_high_q[idx + 1]);
    end
    // FRAME_CNT advances once per frame.
    wait_pan_rise();
    apb_read(A_STATUS, d, e); fc1 = int'(d[31:16]);
    repeat (3) wait_pan_rise();
    apb_read(A_STATUS, d, e); fc2 = int'(d[31:16]);
    checks++;
    if (fc2 - fc1 != 3) begin failures++; $display("FAIL frame_cnt: advanced %0d over 3 frames want 3", fc2 - fc1); end
    // Randomized widths and periods.
    for (int i = 0; i < 3; i++) begin
      p = int'($urandom_range(0, 30)); tp = int'($urandom_range(0, 30)); per = int'($urandom_range(0, 45));
      idx = pan_high_q.size(); idx_t = tilt_high_q.size(); fc1 = pan_rise_q.size();
      apb_write(A_PULSE0, 32'(p)); apb_write(A_PULSE1, 32'(tp)); apb_write(A_PERIOD, 32'(per));
      idx = pan_high_q.size(); idx_t = tilt_high_q.size(); fc1 = pan_rise_q.size();
      for (int k = 0; k < 1000 && (pan_high_q.size() < idx + 2 || tilt_high_q.size() < idx_t + 2 ||
           pan_rise_q.size() < fc1 + 3); k++) @(posedge PCLK);
      checks++;
      if (pan_high_q.size() < idx + 2 || tilt_high_q.size() < idx_t + 2 || pan_rise_q.size() < fc1 + 3) begin
        failures++; $display("FAIL rand_pwm: timeout p=%0d tp=%0d per=%0d", p, tp, per);
      end else begin
        if (pan_high_q[idx + 1] != exp_pulse(p) * P) begin
          failures++; $display("FAIL rand_pan_width: p=%0d got %0d want %0d", p, pan_high_q[idx + 1], exp_pulse(p) * P);
        end
        checks++;
        if (tilt_high_q[idx_t + 1] != exp_pulse(tp) * P) begin
          failures++; $display("FAIL rand_tilt_width: p=%0d got %0d want %0d", tp, tilt_high_q[idx_t + 1], exp_pulse(tp) * P);
        end
        checks++;
        if (pan_rise_q[fc1 + 2] - pan_rise_q[fc1 + 1] != exp_period(per) * P) begin
          failures++; $display("FAIL rand_period_len: per=%0d got %0d want %0d", per,
                               pan_rise_q[fc1 + 2] - pan_rise_q[fc1 + 1], exp_period(per) * P);
        end
      end
    end
    apb_write(A_PERIOD, 32'd40);
    apb_write(A_PULSE0, 32'd12);
  endtask

  task automatic test_en();
    int h0, run;
    repeat (2) wait_pan_rise();
    apb_write(A_CTRL, 32'd0);
    checks++;
    if (PWM_PAN !== 1'b1) begin failures++; $display("FAIL en_clear_same: PWM_PAN=%b want 1 on clearing edge", PWM_PAN); end
    @(posedge PCLK); #1;
    checks++;
    if (PWM_PAN !== 1'b0 || PWM_TILT !== 1'b0) begin
      failures++; $display("FAIL en_clear_next: pan=%b tilt=%b want 0 0", PWM_PAN, PWM_TILT);
    end
    apb_write(A_PULSE0, 32'd6);
    h0 = pan_high_q.size();
    apb_write(A_CTRL, 32'd1);
    @(posedge PCLK); #1;
    checks++;
    if (PWM_PAN !== 1'b1) begin failures++; $display("FAIL en_set_start: PWM_PAN=%b want 1", PWM_PAN); end
    for (int k = 0; k < 200 && pan_high_q.size() <= h0; k++) @(posedge PCLK);
    checks++;
    if (pan_high_q.size() <= h0) begin
      failures++; $display("FAIL en_first_frame: timeout");
    end else begin
      run = pan_high_q[h0];
      if (run < 6 * P - 1 || run > 6 * P) begin
        failures++; $display("FAIL en_first_frame: high %0d cycles want %0d..%0d", run, 6 * P - 1, 6 * P);
      end
    end
  endtask

  task automatic test_fire();
    logic [31:0] d; logic e;
    int f0, run;
    apb_write(A_CTRL, 32'd2);
    apb_write(A_FIRE, 32'd0);
    repeat (2) @(posedge PCLK); #1;
    checks++;
    if (FIRE_OUT !== 1'b0) begin failures++; $display("FAIL fire_bit0_zero: FIRE_OUT=%b want 0", FIRE_OUT); end
    f0 = fire_high_q.size();
    apb_write(A_FIRE, 32'd1);
    checks++;
    if (FIRE_OUT !== 1'b1) begin failures++; $display("FAIL fire_start: FIRE_OUT=%b want 1", FIRE_OUT); end
    apb_read(A_STATUS, d, e); checks++;
    if (d[1:0] !== 2'b01) begin failures++; $display("FAIL fire_busy: status[1:0]=%b want 01", d[1:0]); end
    apb_write(A_FIRE, 32'd1);
    apb_read(A_STATUS, d, e); checks++;
    if (d[1:0] !== 2'b11) begin failures++; $display("FAIL fire_rej_busy: status[1:0]=%b want 11", d[1:0]); end
    for (int k = 0; k < 200 && fire_high_q.size() <= f0; k++) @(posedge PCLK);
    checks++;
    if (fire_high_q.size() <= f0) begin
      failures++; $display("FAIL fire_len: timeout");
    end else begin
      run = fire_high_q[f0];
      if (run < (FLEN - 1) * P + 1 || run > FLEN * P) begin
        failures++; $display("FAIL fire_len: high %0d cycles want %0d..%0d", run, (FLEN - 1) * P + 1, FLEN * P);
      end
    end
    apb_read(A_STATUS, d, e); checks++;
    if (d[1:0] !== 2'b10) begin failures++; $display("FAIL fire_done: status[1:0]=%b want 10", d[1:0]); end
    apb_read(A_FIRE, d, e); checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL fire_read0: got %h want 0", d); end
    apb_write(A_STATUS, 32'd2);
    apb_read(A_STATUS, d, e); checks++;
    if (d[1:0] !== 2'b00) begin failures++; $display("FAIL rej_w1c: status[1:0]=%b want 00", d[1:0]); end
    // Disarmed request
    apb_write(A_CTRL, 32'd0);
    apb_write(A_FIRE, 32'd1);
    run = 0;
    for (int k = 0; k < 6; k++) begin @(posedge PCLK); #1; if (FIRE_OUT !== 1'b0) run++; end
    checks++;
    if (run != 0) begin failures++; $display("FAIL fire_disarmed: FIRE_OUT high %0d cycles want 0", run); end
    apb_read(A_STATUS, d, e); checks++;
    if (d[1:0] !== 2'b10) begin failures++; $display("FAIL rej_disarmed: status[1:0]=%b want 10", d[1:0]); end
    apb_write(A_STATUS, 32'd2);
    // Disarm mid-fire
    apb_write(A_CTRL, 32'd2);
    apb_write(A_FIRE, 32'd1);
    repeat (3) @(posedge PCLK);
    apb_write(A_CTRL, 32'd0);
    checks++;
    if (FIRE_OUT !== 1'b1) begin failures++; $display("FAIL disarm_same: FIRE_OUT=%b want 1", FIRE_OUT); end
    @(posedge PCLK); #1;
    checks++;
    if (FIRE_OUT !== 1'b0) begin failures++; $display("FAIL disarm_next: FIRE_OUT=%b want 0", FIRE_OUT); end
    apb_read(A_STATUS, d, e); checks++;
    if (d[1:0] !== 2'b00) begin failures++; $display("FAIL disarm_status: status[1:0]=%b want 00", d[1:0]); end
  endtask

  task automatic test_preset();
    logic [31:0] d; logic e;
    apb_write(A_PULSE0, 32'd20);
    apb_write(A_PULSE1, 32'd20);
    apb_write(A_CTRL, 32'd3);
    repeat (2) wait_pan_rise();
    apb_write(A_FIRE, 32'd1);
    repeat (2) @(posedge PCLK); #1;
    checks++;
    if ({PWM_PAN, PWM_TILT, FIRE_OUT} !== 3'b111) begin
      failures++; $display("FAIL preset_pre: pan/tilt/fire=%b want 111", {PWM_PAN, PWM_TILT, FIRE_OUT});
    end
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    checks++;
    if ({PWM_PAN, PWM_TILT, FIRE_OUT} !== 3'b000) begin
      failures++; $display("FAIL preset_outputs: pan/tilt/fire=%b want 000", {PWM_PAN, PWM_TILT, FIRE_OUT});
    end
    PRESET = 1'b0;
    apb_read(A_CTRL, d, e); checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL preset_ctrl: got %h want 0", d); end
    apb_read(A_PULSE0, d, e); checks++;
    if (d !== 32'(exp_pulse(1500))) begin failures++; $display("FAIL preset_pulse0: got %0d want %0d", d, exp_pulse(1500)); end
    apb_read(A_STATUS, d, e); checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL preset_status: got %h want 0", d); end
  endtask

  initial begin
    checks = 0; failures = 0;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'd0; PWDATA = 32'd0;
    test_reset();
    test_regs();
    test_pwm();
    test_en();
    test_fire();
    test_preset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_turret_pwm.md
Name: apb_turret_pwm

Overview:
- APB3 slave in the FPGA fabric, directly downstream of the MSS fabric APB master (MSSPSEL/MSSPENABLE/MSSPWRITE/MSSPADDR/MSSPWDATA in, MSSPRDATA/MSSPREADY/MSSPSLVERR out).
- Drives two servo PWM channels (pan, tilt) plus a one-shot fire solenoid pulse.
- Firmware writes pulse widths at any time. Hardware applies them glitch-free at frame boundaries.

Parameters:
PRESCALE, 100, PCLK cycles per tick (1 us at 100 MHz)
PERIOD_RST, 20000, reset frame period in ticks
MIN_PULSE, 1000, lower clamp for pulse registers (ticks)
MAX_PULSE, 2000, upper clamp for pulse registers (ticks)
FIRE_LEN, 50000, fire pulse length in ticks

Ports:
PCLK  in  1  fabric clock (FAB_CLK)
PRESET  in  1  synchronous active-high reset
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PADDR  in  8  byte address; [4:2] used
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  tied 1; zero wait states
PSLVERR  out  1  error on unmapped offset
PWM_PAN  out  1  pan servo PWM
PWM_TILT  out  1  tilt servo PWM
FIRE_OUT  out  1  solenoid drive

Behaviour:
- One clock. Reset is synchronous and active-high on PRESET.
- Reset values:
  - all outputs 0 (PREADY 1).
  - CTRL=0, PERIOD=PERIOD_RST, PULSE0=PULSE1=1500 (clamped), STATUS=0.
  - all counters 0.
- Write commits on the PCLK edge where PSEL & PENABLE & PWRITE.
- PRDATA is combinational from the decoded register when PSEL=1, else 0. Unused bits read 0.
- PSLVERR = PSEL & PENABLE & (PADDR[4:2] > 5). Unmapped writes have no effect.
- Register map:
  - 0x00 CTRL RW: [0] EN, [1] ARM.
  - 0x04 PERIOD RW [15:0]. A write below MAX_PULSE+1 is stored as MAX_PULSE+1.
  - 0x08 PULSE0 RW [15:0]. Write is clamped to [MIN_PULSE, MAX_PULSE]; readback returns the clamped value.
  - 0x0C PULSE1 RW, same rule as PULSE0.
  - 0x10 FIRE WO: a write with bit0=1 requests fire. Reads return 0.
  - 0x14 STATUS: [0] FIRE_BUSY (RO); [1] FIRE_REJ (sticky, W1C); [31:16] FRAME_CNT (RO, 16-bit wrap).
- Tick generator:
  - Counter runs 0..PRESCALE-1 at all times.
  - tick is a 1-cycle pulse when the count equals PRESCALE-1.
- Frame counter:
  - When EN=0: frame counter held at 0, shadows continuously track PERIOD/PULSE0/PULSE1, PWM outputs 0 (registered; low the cycle after EN clears).
  - When EN=1: counts ticks 0..period_sh-1.
  - On the tick where count = period_sh-1: count wraps to 0, shadows reload from live registers, FRAME_CNT increments.
  - A write coinciding with the wrap cycle lands in the live register only and takes effect the following frame.
- PWM outputs (registered):
  - PWM_PAN = EN & (frame_cnt < pulse0_sh).
  - PWM_TILT = EN & (frame_cnt < pulse1_sh).
- Fire FSM states: IDLE, FIRING.
  - IDLE -> FIRING on a FIRE request when ARM=1. FIRE_OUT=1, FIRE_BUSY=1, length counter=0.
  - A request in FIRING or with ARM=0 sets FIRE_REJ; no state change.
  - FIRING counts ticks. On the tick where the count reaches FIRE_LEN-1: -> IDLE, FIRE_OUT=0 next cycle.
  - ARM cleared while FIRING: -> IDLE, FIRE_OUT=0 on the next cycle.
  - Fire is independent of EN.
- W1C of FIRE_REJ in the same cycle as a new reject: the set wins.
- PRESET mid-frame or mid-fire: all state returns to reset values on the next edge.

Decomposition:
- Package turret_pkg:
  - register offset constants (CTRL, PERIOD, PULSE0, PULSE1, FIRE, STATUS).
  - CTRL/STATUS bit index constants.
  - fire_state_t enum.
- Sub-module pwm_channel (compare of frame count vs shadow pulse, registered output), instantiated twice.

Test Plan (PRESCALE=2, PERIOD_RST=40, MIN_PULSE=5, MAX_PULSE=20, FIRE_LEN=10):
- Reset, read all offsets -> CTRL=0, PERIOD=40, PULSE0=PULSE1=20 (1500 clamped), STATUS=0; PWM/FIRE low; PREADY=1.
- Write PULSE0=3, PULSE1=99, read back -> 5 and 20. Write PERIOD=10, read -> 21. Access offset 0x18 -> PSLVERR=1, PRDATA=0.
- EN=1, PULSE0=8 -> PWM_PAN high 16 PCLK per 80-PCLK frame. Write PULSE0=12 mid-frame -> current frame stays 16 high, next frame 24; FRAME_CNT increments per frame.
- Clear EN mid-pulse -> PWM_PAN low the next cycle. Set EN -> new frame starts at count 0 with current registers.
- ARM=1, FIRE=1 -> FIRE_OUT high 20 PCLK, BUSY=1 throughout. Second FIRE during pulse -> FIRE_REJ=1, pulse unchanged. W1C STATUS bit1 -> 0.
- FIRE with ARM=0 -> no pulse, FIRE_REJ=1. Clear ARM mid-fire -> FIRE_OUT low next cycle. Assert PRESET mid-frame -> all outputs 0 next edge.
